feedback_echo: RTL and testbench



---
 rtl/audio_dsp_pkg.sv | 30 +++
 rtl/echo_delay_ram.sv | 30 +++
 rtl/feedback_echo.sv | 172 +++++++++++++++++
 tb/tb_feedback_echo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_dsp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_dsp_pkg : shared gain constants, saturation helper and FSM states  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package audio_dsp_pkg;

  localparam int GAIN_W    = 4;
  localparam int GAIN_FRAC = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RD    = 2'd2,
    ST_CALC  = 2'd3
  } state_t;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_delay_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | echo_delay_ram : single-port delay memory, registered read, no reset     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module echo_delay_ram #(
  parameter int DEPTH  = 24000,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/feedback_echo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | feedback_echo : run-time length comb echo with feedback/wet gains        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module feedback_echo
  import audio_dsp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DELAY_LEN = 24000,
  parameter int ADDR_W    = $clog2(DELAY_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        delay_len,
  input  logic [GAIN_W-1:0]        fb_gain,
  input  logic [GAIN_W-1:0]        wet_gain,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     overrun
);

  localparam int PTR_W  = $clog2(DELAY_LEN);
  localparam int LEN_W  = $clog2(DELAY_LEN + 1);
  localparam int PROD_W = DATA_W + GAIN_W + 1;

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d, clr_q, clr_d, addr_q, addr_d;
  logic [LEN_W-1:0]           len_q, len_d, len_in;
  logic signed [DATA_W-1:0]   in_q, in_d, d_q, d_d;
  logic                       en_q, en_d;
  logic [GAIN_W-1:0]          fbg_q, fbg_d, wetg_q, wetg_d;
  logic                       out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic signed [DATA_W-1:0]   out_sample_q, out_sample_d;

  logic                       ram_we, ram_re;
  logic [PTR_W-1:0]           ram_addr, rd_addr;
  logic [DATA_W-1:0]          ram_wdata, ram_rdata;

  logic signed [PROD_W-1:0]   fb_prod, wet_prod, fb_sh, wet_sh;
  logic signed [31:0]         sum_fb, sum_wet;
  logic signed [DATA_W-1:0]   wr_val, out_val;

  echo_delay_ram #(
    .DEPTH  (DELAY_LEN),
    .WIDTH  (DATA_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Length 0 means 1; anything past the physical depth means full depth.
  always_comb begin
    if (delay_len == '0)                     len_in = LEN_W'(1);
    else if (int'(delay_len) > DELAY_LEN)    len_in = LEN_W'(DELAY_LEN);
    else                                     len_in = LEN_W'(delay_len);
    rd_addr = (int'(ptr_q) >= int'(len_in)) ? '0 : ptr_q;
  end

  assign fb_prod  = PROD_W'(d_q) * PROD_W'($signed({1'b0, fbg_q}));
  assign wet_prod = PROD_W'(d_q) * PROD_W'($signed({1'b0, wetg_q}));
  assign fb_sh    = fb_prod  >>> GAIN_FRAC;
  assign wet_sh   = wet_prod >>> GAIN_FRAC;
  assign sum_fb   = 32'(in_q) + 32'(fb_sh);
  assign sum_wet  = 32'(in_q) + 32'(wet_sh);
  assign wr_val   = en_q ? DATA_W'(sat(sum_fb, DATA_W))  : in_q;
  assign out_val  = en_q ? DATA_W'(sat(sum_wet, DATA_W)) : in_q;

  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clr_d        = clr_q;
    addr_d       = addr_q;
    len_d        = len_q;
    in_d         = in_q;
    en_d         = en_q;
    fbg_d        = fbg_q;
    wetg_d       = wetg_q;
    d_d          = d_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    overrun_d    = overrun_q | (in_valid & ~in_ready);
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = addr_q;
    ram_wdata    = wr_val;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = '0;
        if (int'(clr_q) == DELAY_LEN - 1) state_d = ST_IDLE;
        else                              clr_d   = clr_q + PTR_W'(1);
      end
      ST_IDLE: begin
        if (in_valid) begin
          in_d     = in_sample;
          en_d     = enable;
          len_d    = len_in;
          fbg_d    = fb_gain;
          wetg_d   = wet_gain;
          addr_d   = rd_addr;
          ram_re   = 1'b1;
          ram_addr = rd_addr;
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        d_d     = ram_rdata;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        ram_we       = 1'b1;
        out_valid_d  = 1'b1;
        out_sample_d = out_val;
        ptr_d        = (int'(addr_q) + 1 >= int'(len_q)) ? '0 : addr_q + PTR_W'(1);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      clr_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      in_q         <= '0;
      en_q         <= 1'b0;
      fbg_q        <= '0;
      wetg_q       <= '0;
      d_q          <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clr_q        <= clr_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      in_q         <= in_d;
      en_q         <= en_d;
      fbg_q        <= fbg_d;
      wetg_q       <= wetg_d;
      d_q          <= d_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_feedback_echo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_feedback_echo : scoreboard bench for feedback_echo (8-sample buffer)  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_feedback_echo;

  localparam int DW = 16;
  localparam int DL = 8;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_sample = '0;
  logic                 in_ready;
  logic [AW-1:0]        delay_len = 4'd4;
  logic [3:0]           fb_gain = 4'd0;
  logic [3:0]           wet_gain = 4'd8;
  logic                 out_valid;
  logic signed [DW-1:0] out_sample;
  logic                 overrun;

  feedback_echo #(
    .DATA_W    (DW),
    .DELAY_LEN (DL),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .delay_len  (delay_len),
    .fb_gain    (fb_gain),
    .wet_gain   (wet_gain),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mbuf[DL];
  int mptr = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int msat(input int v);
    if (v > 32767)       return 32767;
    else if (v < -32768) return -32768;
    else                 return v;
  endfunction

  // Reference behaviour of one accepted sample using the current control inputs.
  task automatic model_step(input int s, output int o);
    int l, a, d, fb, wet, w;
    if (delay_len == 0)              l = 1;
    else if (int'(delay_len) > DL)   l = DL;
    else                             l = int'(delay_len);
    a   = (mptr >= l) ? 0 : mptr;
    d   = mbuf[a];
    fb  = (d * int'(fb_gain)) >>> 4;
    wet = (d * int'(wet_gain)) >>> 4;
    w   = enable ? msat(s + fb) : s;
    o   = enable ? msat(s + wet) : s;
    mbuf[a] = w;
    mptr = (a + 1 >= l) ? 0 : a + 1;
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_sample", int'(out_sample), e);
      end
    end
  end

  task automatic send(input int s, input bit use_c, input int cexp);
    int m;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      in_sample = 16'(s);
      model_step(s, m);
      exp_q.push_back(use_c ? cexp : m);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    int n;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DL; i++) mbuf[i] = 0;
    mptr = 0;
    exp_q.delete();
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
    end
    check("clear_cycles", n, DL);
  endtask

  int tab_a[12] = '{1000, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0};
  int tab_b[16] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125, 0, 0, 0};

  initial begin
    int n;
    bit dirty;
    int s;

    // Reset values and clear sequence with a sample offered mid-clear.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    n = 0;
    dirty = 1'b0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
      if (out_valid || out_sample != 0) dirty = 1'b1;
      in_valid = (n == 3);
    end
    in_valid = 1'b0;
    check("clear_cycles", n, DL);
    check("clear_outputs_quiet", int'(dirty), 0);
    check("overrun_in_clear", int'(overrun), 1);

    // Impulse, no feedback.
    do_reset();
    delay_len = 4'd4; wet_gain = 4'd8; fb_gain = 4'd0; enable = 1'b1;
    for (int i = 0; i < 12; i++) send((i == 0) ? 1000 : 0, 1'b1, tab_a[i]);
    drain();

    // Impulse with half feedback.
    do_reset();
    fb_gain = 4'd8;
    for (int i = 0; i < 16; i++) send((i == 0) ? 1000 : 0, 1'b1, tab_b[i]);
    drain();

    // Saturation both rails.
    do_reset();
    delay_len = 4'd1; wet_gain = 4'd15; fb_gain = 4'd0;
    send(32000, 1'b1, 32000);
    send(32000, 1'b1, 32767);
    drain();
    do_reset();
    send(-32000, 1'b1, -32000);
    send(-32000, 1'b1, -32768);
    drain();
    fb_gain = 4'd15;
    for (int i = 0; i < 4; i++) send(30000, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(-30000, 1'b0, 0);
    drain();

    // Back-to-back strobes: second dropped, result exactly 2 cycles later.
    do_reset();
    delay_len = 4'd4; wet_gain = 4'd8; fb_gain = 4'd0;
    in_sample = 16'sd1234;
    model_step(1234, s);
    exp_q.push_back(1234);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_sample = 16'sd777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("overrun_set", int'(overrun), 1);
    check("lat_e1_out_valid", int'(out_valid), 0);
    check("lat_e1_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("lat_e2_out_valid", int'(out_valid), 1);
    check("lat_e2_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("lat_e3_out_valid", int'(out_valid), 0);
    check("hold_out_sample", int'(out_sample), 1234);
    check("overrun_sticky", int'(overrun), 1);
    drain();

    // Reset while a sample is in flight: no result may appear.
    in_sample = 16'sd555;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("abandon_out_valid", int'(out_valid), 0);
    repeat (4) @(posedge clk);
    #1;

    // Random mix, shortened length, bypass, and out-of-range lengths.
    delay_len = 4'd8; fb_gain = 4'd6; wet_gain = 4'd11; enable = 1'b1;
    for (int i = 0; i < 13; i++) send(int'($urandom_range(40000)) - 20000, 1'b0, 0);
    delay_len = 4'd3;
    for (int i = 0; i < 8; i++) begin
      enable = i[0];
      send(int'($urandom_range(40000)) - 20000, 1'b0, 0);
    end
    enable = 1'b0;
    send(-4321, 1'b1, -4321);
    enable = 1'b1;
    delay_len = 4'd0;
    for (int i = 0; i < 4; i++) send(int'($urandom_range(40000)) - 20000, 1'b0, 0);
    delay_len = 4'd12;
    fb_gain = 4'd15; wet_gain = 4'd3;
    for (int i = 0; i < 20; i++) send(int'($urandom_range(60000)) - 30000, 1'b0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
